// File: rtl/image_rom_reader_pkg.sv
// Shared constants and types for the image ROM read client.
package image_rom_pkg;

  localparam int ROM_ADDR_W       = 11;
  localparam int ROM_DATA_W       = 18;
  localparam int ROM_LATENCY_DFLT = 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } rd_state_t;

  // One stream beat: data word plus end-of-burst marker.
  typedef struct packed {
    logic                  last;
    logic [ROM_DATA_W-1:0] data;
  } stream_word_t;

endpackage

// File: rtl/image_rom_reader_if.sv
// Valid/ready pixel-word stream between the ROM reader and downstream logic.
interface image_rom_reader_if #(
  parameter int DATA_W = image_rom_pkg::ROM_DATA_W
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/image_rom_reader_fifo.sv
// Show-ahead skid FIFO holding {last, data} beats returned by the ROM.
module image_rom_fifo
  import image_rom_pkg::*;
#(
  parameter type word_t = stream_word_t,
  parameter int  DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  word_t                      wr_word,
  input  logic                       pop,
  output word_t                      head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  word_t         mem [DEPTH];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // Head is forced to zero when empty so the stream outputs read 0 out of reset.
  assign head  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/image_rom_reader.sv
// Sequential burst reader for the pipelined image ROM, presenting words as a stream.
module image_rom_reader
  import image_rom_pkg::*;
#(
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int DATA_W      = ROM_DATA_W,
  parameter int ROM_LATENCY = ROM_LATENCY_DFLT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_ad,
  input  logic [DATA_W-1:0]   rom_data,
  image_rom_reader_if.master  m
);
  localparam int IFW = $clog2(ROM_LATENCY + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;
  localparam logic [ADDR_W:0] ONE_LEFT = (ADDR_W + 1)'(1);

  if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_depth_check
    $error("image_rom_reader: FIFO_DEPTH must be at least ROM_LATENCY+1");
  end

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  rd_state_t            state;
  logic [ADDR_W:0]      remaining;
  logic [ROM_LATENCY-1:0] vpipe;
  logic [ROM_LATENCY-1:0] lpipe;
  logic [IFW-1:0]       in_flight;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  word_t                head;
  word_t                wr_word;

  // A ROM return is valid exactly when its issue bit reaches the end of the pipe.
  assign push    = vpipe[ROM_LATENCY-1];
  assign wr_word = '{last: lpipe[ROM_LATENCY-1], data: rom_data};
  assign pop     = m.m_valid & m.m_ready;

  assign m.m_valid = ~fifo_empty;
  assign m.m_data  = head.data;
  assign m.m_last  = head.last;

  // Credit check: outstanding reads plus buffered words must fit the FIFO,
  // treating this cycle's pop as a slot already freed.
  always_comb begin
    issue = 1'b0;
    if (state == FETCH) begin
      issue = (OW'(in_flight) + OW'(fifo_count)) < (OW'(FIFO_DEPTH) + OW'(pop));
    end
  end

  // Burst control FSM; rom_ad doubles as the next-address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_ad    <= '0;
      remaining <= '0;
      vpipe     <= '0;
      lpipe     <= '0;
      in_flight <= '0;
    end else begin
      done      <= 1'b0;
      vpipe     <= (vpipe << 1) | ROM_LATENCY'(issue);
      lpipe     <= (lpipe << 1) | ROM_LATENCY'(issue && (remaining == ONE_LEFT));
      in_flight <= in_flight + IFW'(issue) - IFW'(push);
      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              rom_ad    <= base;
              remaining <= count;
              busy      <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            rom_ad    <= rom_ad + ADDR_W'(1);
            remaining <= remaining - ONE_LEFT;
            if (remaining == ONE_LEFT) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  image_rom_fifo #(
    .word_t (word_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_word (wr_word),
    .pop     (pop),
    .head    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_image_rom_reader.sv
// Randomized bench for image_rom_reader with a two-stage pipelined ROM model.
module tb_image_rom_reader;

  localparam int AW    = 11;
  localparam int DW    = 18;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_ad;
  logic [DW-1:0] rom_data;

  logic [DW-1:0] rom [2048];
  logic [AW-1:0] rom_addr_q;

  int checks = 0;
  int errors = 0;

  image_rom_reader_if #(.DATA_W(DW)) sif ();

  image_rom_reader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .ROM_LATENCY (2),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .rom_ad   (rom_ad),
    .rom_data (rom_data),
    .m        (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: address register then output register, always enabled.
  always @(posedge clk) begin
    rom_addr_q <= rom_ad;
    rom_data   <= rom[rom_addr_q];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c - 1) % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return c > 10;
    endcase
  endfunction

  // Expected stream is the address sequence base, base+1, ... mod 2048.
  task automatic run_burst(input int b, input int n, input int mode, input int inject);
    logic [DW-1:0] qd[$];
    logic          ql[$];
    logic [AW-1:0] ab;
    logic [AW-1:0] a;
    logic [AW-1:0] diff;
    int c, acc, done_due, first, max_out, budget, outst;
    c = 0; acc = 0; done_due = -1; first = -1; max_out = 0;
    ab = AW'(b);
    for (int i = 0; i < n; i++) begin
      a = AW'(b + i);
      qd.push_back(rom[a]);
      ql.push_back(i == n - 1);
    end
    budget = 4 * n + 60;
    @(negedge clk);
    base = ab; count = (AW + 1)'(n); start = 1'b1; sif.m_ready = ready_for(mode, 0);
    while (1) begin
      @(negedge clk);
      c++;
      start = (c == inject);
      if (c == inject) begin base = 11'd100; count = 12'd8; end
      sif.m_ready = ready_for(mode, c);
      #1;
      if (c == 1) check("busy_high", busy, 1);
      diff  = rom_ad - ab;
      outst = int'(diff) - acc;
      if (outst > max_out) max_out = outst;
      check("done_pulse", done, c == done_due);
      if (c == done_due) begin
        check("busy_after_done", busy, 0);
        check("valid_after_done", sif.m_valid, 0);
        break;
      end
      if (sif.m_valid) begin
        if (first < 0) begin
          first = c;
          check("first_valid_cycle", c, 4);
        end
        check("word_expected", qd.size() > 0, 1);
        if (qd.size() > 0) begin
          check("m_data", sif.m_data, qd[0]);
          check("m_last", sif.m_last, ql[0]);
          if (sif.m_ready) begin
            if (mode == 0) check("accept_cycle", c, 4 + acc);
            if (ql[0]) done_due = c + 1;
            void'(qd.pop_front());
            void'(ql.pop_front());
            acc++;
          end
        end
      end
      if (c >= budget) begin
        check("burst_timeout", c, 0);
        break;
      end
    end
    check("word_count", acc, n);
    check("outstanding_le_depth", max_out <= DEPTH, 1);
    if (mode == 3) check("stall_outstanding", max_out, DEPTH);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = DW'($urandom);
    reset = 1'b1; start = 1'b0; base = '0; count = '0; sif.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_ad", rom_ad, 0);
    check("rst_valid", sif.m_valid, 0);
    check("rst_last", sif.m_last, 0);
    check("rst_data", sif.m_data, 0);
    @(negedge clk);
    reset = 1'b0;

    run_burst(0, 8, 0, 0);
    run_burst(2046, 4, 0, 0);
    run_burst(40, 16, 1, 0);
    run_burst(900, 16, 2, 0);
    run_burst(600, 16, 3, 0);
    run_burst(50, 8, 0, 3);

    // Zero-length request completes immediately without a burst.
    @(negedge clk);
    base = 11'd77; count = '0; start = 1'b1; sif.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_valid", sif.m_valid, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("zero_quiet_valid", sif.m_valid, 0);
      check("zero_single_done", done, 0);
    end

    // Reset in the middle of fetching with two reads outstanding.
    @(negedge clk);
    base = 11'd300; count = 12'd8; start = 1'b1; sif.m_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rom_ad", rom_ad, 0);
    check("mid_rst_valid", sif.m_valid, 0);
    check("mid_rst_last", sif.m_last, 0);
    check("mid_rst_data", sif.m_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("post_rst_no_stale", sif.m_valid, 0);
    end
    run_burst(5, 2, 0, 0);

    for (int k = 0; k < 6; k++) begin
      run_burst(int'($urandom_range(0, 2047)), int'($urandom_range(1, 24)), 2, 0);
    end
    run_burst(int'($urandom_range(0, 2047)), 2048, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_rom_reader.md
Name: image_rom_reader

Overview:
- Read-side client for the pipelined image ROM.
- Issues sequential addresses and absorbs the ROM's fixed read latency. The ROM's output enable is tied high, so it cannot stall.
- Presents the words as a valid/ready stream to downstream pixel logic.
- Sustains one word per cycle when downstream is always ready, and never loses a word under backpressure.

Parameters:
- ADDR_W, 11, ROM address width (2048 words).
- DATA_W, 18, ROM word width.
- ROM_LATENCY, 2, cycles from rom_ad driven to matching rom_data valid (address register plus output register).
- FIFO_DEPTH, 4, skid FIFO entries. Must be >= ROM_LATENCY+1; checked at elaboration.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst; honoured only in IDLE.
- base  in  ADDR_W  first word address, sampled with start.
- count  in  ADDR_W+1  number of words, 0..2^ADDR_W, sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last word is accepted downstream, or when a count=0 start is accepted.
- rom_ad  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM read data.
- m_data  out  DATA_W  stream data (FIFO head).
- m_valid  out  1  stream valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high with the final word of the burst.

Behaviour:
- Reset values: busy=0, done=0, rom_ad=0, m_valid=0, m_last=0, m_data=0. FIFO is empty and all counters are cleared.
- Reset asserted mid-burst aborts the burst immediately. In-flight ROM returns are discarded because the valid-tracking shift register is cleared.
- State machine: IDLE, FETCH, DRAIN.
- IDLE:
  - start with count=0 -> done pulse next cycle; stay in IDLE.
  - start with count>0 -> latch base/count, go to FETCH, busy=1.
- FETCH: each cycle, issue a read when in_flight + fifo_count < FIFO_DEPTH, counting the current-cycle pop as a free slot.
  - Issue = drive rom_ad=next_addr and shift a 1 into the ROM_LATENCY-deep valid pipe.
  - next_addr increments modulo 2^ADDR_W, so base=2047 wraps to 0.
  - The pipe also carries a last flag, set on the issue where remaining becomes 0.
  - When the final word is issued, go to DRAIN.
- DRAIN: no issues. When the word flagged last is accepted (m_valid & m_ready & m_last), pulse done, clear busy, and go to IDLE.
- start while busy is ignored, with no effect on base, count or the burst in progress.
- Latency:
  - Word k is issued in cycle t; rom_data is captured into the FIFO at end of cycle t+ROM_LATENCY.
  - FIFO push and pop in the same cycle is legal. The FIFO is show-ahead, so m_valid rises the cycle after the push.
  - First m_valid occurs 1+ROM_LATENCY+1 cycles after the start cycle (4 at default).
- Backpressure: the credit rule guarantees the FIFO never overflows; the push into a full FIFO is an assertion error.
  - With m_ready held low, at most FIFO_DEPTH words are fetched and then issue stalls.
  - Resuming m_ready restores one word per cycle.
- m_data and m_last hold stable while m_valid=1 and m_ready=0.
- in_flight counter range: 0..ROM_LATENCY, width clog2(ROM_LATENCY+1).
- remaining counter: ADDR_W+1 bits, so count=2048 is legal.

Decomposition:
- Package image_rom_pkg holds:
  - ROM_ADDR_W and ROM_DATA_W constants;
  - ROM_LATENCY default;
  - state enum rd_state_t {IDLE, FETCH, DRAIN};
  - stream word typedef {last, data}.
- One sub-module, image_rom_fifo:
  - synchronous show-ahead FIFO of {last, data}, with push/pop/count/full/empty;
  - asynchronous active-high reset.

Test Plan:
- base=0, count=8, m_ready=1 -> m_valid first at cycle start+4; data = ROM[0..7] on 8 consecutive cycles; m_last on the 8th; done 1 cycle after it accepts (same cycle as acceptance edge); busy low afterwards.
- base=2046, count=4 -> words ROM[2046], ROM[2047], ROM[0], ROM[1]; m_last on ROM[1].
- count=16 with m_ready toggling 1,0,0,1,... plus a random pattern -> all 16 words arrive in order with none dropped or duplicated; the FIFO-overflow assertion never fires; stall shows at most 4 issues ahead of acceptance.
- start pulse at cycle 3 of a count=8 burst with base=100 -> ignored; the original burst completes unchanged.
- start with count=0 -> done pulse next cycle; busy stays 0; no m_valid.
- reset asserted during FETCH with 2 reads in flight -> all outputs go to 0 asynchronously; after release, no stale m_valid; a new burst (base=5, count=2) returns ROM[5], ROM[6].
